scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter: DWELL_W, 8, width of the dwell count.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  level-sampled request to begin scanning from IDLE.
REQ-005 Port: stop  input  1  abort request, honoured in any state.
REQ-006 Port: oneshot  input  1  1 = single sweep then IDLE; 0 = continuous; sampled with start.
REQ-007 Port: dwell  input  DWELL_W  cycles-per-channel minus one; sampled at each channel entry.
REQ-008 Port: ch_mask  input  8  channel enable bits, bit n enables channel n.
REQ-009 Port: S  output  3  channel select, feeds the 3:8 decoder select input directly.
REQ-010 Port: active  output  1  high while S is valid and its channel is being driven.
REQ-011 Port: sweep_done  output  1  one-cycle pulse at completion of each full sweep.
REQ-012 Port: err  output  1  one-cycle pulse when no channel is enabled at start or at an advance.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 FSM states SHALL be IDLE and RUN only.
REQ-015 IDLE: S=0, active=0; start=1 with an enabled channel -> RUN next edge, S=lowest enabled index, dwell counter=0.
REQ-016 start=1 with no enabled channel SHALL stay IDLE and pulse err for one cycle.
REQ-017 RUN: counter increments each cycle; at counter==dwell, S advances to the next enabled index above S, counter clears; each channel held exactly dwell+1 cycles (dwell=0 -> 1 cycle).
REQ-018 Advance past the highest enabled index SHALL wrap to the lowest enabled index and pulse sweep_done in the cycle S takes the wrapped value.
REQ-019 oneshot sweep: at the wrap point the block SHALL instead go to IDLE (S=0, active=0) with sweep_done pulsed in that same cycle.
REQ-020 ch_mask SHALL be evaluated only at advance; masking the current channel mid-dwell SHALL not shorten its dwell.
REQ-021 All-zero ch_mask at an advance SHALL force IDLE and pulse err; sweep_done SHALL not pulse.
REQ-022 stop=1 SHALL force IDLE on the next edge (S=0, active=0, counter=0, no sweep_done); stop wins over start and over a simultaneous advance.
REQ-023 start while in RUN SHALL be ignored.
REQ-024 Single enabled channel: S stays constant and sweep_done pulses every dwell+1 cycles.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, S=0, active=0, sweep_done=0, err=0, counter=0, including mid-dwell.
REQ-026 After rst_n deassertion the block SHALL remain IDLE until start is sampled high.

Configuration
REQ-027 Macro SCAN_SKIP_EN defined: masking behaviour per REQ-008/015-021.
REQ-028 SCAN_SKIP_EN undefined: ch_mask SHALL be ignored, all 8 channels visited 0..7, err SHALL be tied 0.

Verification
REQ-029 mask=8'hFF, dwell=0, oneshot=0, start 1 cycle -> S=0,1,...,7,0 one per cycle; sweep_done on cycle S returns to 0.
REQ-030 mask=8'b1010_0100, dwell=2, oneshot=1 -> S=2x3, 5x3, 7x3 then IDLE, sweep_done with active=0 same cycle.
REQ-031 mask=8'h00, start -> stays IDLE, err one pulse; with SCAN_SKIP_EN undefined -> scans 0..7, err=0.
REQ-032 Running at S=3, counter=1, assert stop and start together -> next cycle IDLE, S=0, no sweep_done.
REQ-033 Running, clear ch_mask bit of current channel mid-dwell -> full dwell kept, channel skipped next sweep.
REQ-034 rst_n low asynchronously mid-dwell at S=5 -> outputs zero before next clk edge; restart begins at lowest enabled channel.

Source files
------------

// File: rtl/scan_sequencer.sv
// scan_sequencer
// ---------------------------------------------------------------------------
// Steps a 3-bit channel select through the channels of an 8-way analog mux.
// Each channel is held for dwell+1 cycles. The sequencer runs a single sweep
// or sweeps continuously, and can be aborted at any time with stop.
//
// Build option:
//   SCAN_SKIP_EN  defined   : ch_mask selects which channels are visited, and
//                             err flags an empty mask.
//                 undefined : ch_mask is ignored, channels 0..7 are all
//                             visited, and err is tied low.
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   start       request to begin scanning (sampled only in IDLE)
//   stop        abort; forces IDLE on the next edge and wins over everything
//   oneshot     1 = single sweep then IDLE, 0 = continuous (sampled with start)
//   dwell       cycles per channel minus one (sampled at each channel entry)
//   ch_mask     channel enable bits, bit n enables channel n
//   S           channel select for the 3:8 decoder
//   active      high while S is valid and its channel is being driven
//   sweep_done  one-cycle pulse when a full sweep completes
//   err         one-cycle pulse when no channel is enabled at start or advance
// ---------------------------------------------------------------------------
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               oneshot,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         ch_mask,
    output logic [2:0]         S,
    output logic               active,
    output logic               sweep_done,
    output logic               err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [2:0]         s_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               oneshot_q, oneshot_d;
    logic               sd_d, err_d;
    logic [7:0]         mask_eff;
    logic [3:0]         first_en, next_en;

    // {found, index} of the lowest set bit of m
    function automatic logic [3:0] lowest_en(input logic [7:0] m);
        lowest_en = 4'b0000;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowest_en = {1'b1, 3'(i)};
    endfunction

    // {found, index} of the lowest set bit of m strictly above cur
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        next_above = 4'b0000;
        for (int i = 7; i >= 0; i--)
            if (m[i] && (i > int'(cur))) next_above = {1'b1, 3'(i)};
    endfunction

`ifdef SCAN_SKIP_EN
    assign mask_eff = ch_mask;
`else
    assign mask_eff = 8'hFF;
`endif

    assign first_en = lowest_en(mask_eff);
    assign next_en  = next_above(mask_eff, S);

    // The mask is only looked at on entry and at an advance, so clearing the
    // current channel's bit mid-dwell never shortens its dwell.
    always_comb begin
        state_d   = state_q;
        s_d       = S;
        cnt_d     = cnt_q;
        dwell_d   = dwell_q;
        oneshot_d = oneshot_q;
        sd_d      = 1'b0;
        err_d     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start && !stop) begin
                if (first_en[3]) begin
                    state_d   = ST_RUN;
                    s_d       = first_en[2:0];
                    cnt_d     = '0;
                    dwell_d   = dwell;
                    oneshot_d = oneshot;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (stop) begin
            state_d = ST_IDLE;
            s_d     = 3'd0;
            cnt_d   = '0;
        end else if (cnt_q != dwell_q) begin
            cnt_d = cnt_q + DWELL_W'(1);
        end else if (!first_en[3]) begin
            // mask emptied while running: abandon the sweep without sweep_done
            state_d = ST_IDLE;
            s_d     = 3'd0;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else if (next_en[3]) begin
            s_d     = next_en[2:0];
            cnt_d   = '0;
            dwell_d = dwell;
        end else begin
            // wrapping past the highest enabled channel completes a sweep
            sd_d  = 1'b1;
            cnt_d = '0;
            if (oneshot_q) begin
                state_d = ST_IDLE;
                s_d     = 3'd0;
            end else begin
                s_d     = first_en[2:0];
                dwell_d = dwell;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            S          <= 3'd0;
            cnt_q      <= '0;
            dwell_q    <= '0;
            oneshot_q  <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            S          <= s_d;
            cnt_q      <= cnt_d;
            dwell_q    <= dwell_d;
            oneshot_q  <= oneshot_d;
            sweep_done <= sd_d;
        end
    end

    // active is exactly the RUN state flop, so it is registered by construction
    assign active = (state_q == ST_RUN);

`ifdef SCAN_SKIP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= err_d;
    end
`else
    assign err = 1'b0;
    logic unused_in;
    assign unused_in = err_d ^ (^ch_mask);
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Testbench for scan_sequencer: a directed vector table, hand-written corner
// sequences, and a randomized run, all checked against a sweep-level model.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, oneshot;
    logic [7:0] dwell;
    logic [7:0] ch_mask;
    logic [2:0] S;
    logic       active, sweep_done, err;

    scan_sequencer #(.DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .oneshot(oneshot),
        .dwell(dwell), .ch_mask(ch_mask), .S(S), .active(active),
        .sweep_done(sweep_done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: which channel we are on and how many more cycles it stays
    bit m_run;
    int m_ch;
    int m_left;
    bit m_os;
    bit exp_sd, exp_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic bit [7:0] eff_mask(input logic [7:0] m);
`ifdef SCAN_SKIP_EN
        return m;
`else
        return 8'hFF;
`endif
    endfunction

    task automatic model_reset();
        m_run = 0; m_ch = 0; m_left = 0; m_os = 0; exp_sd = 0; exp_err = 0;
    endtask

    task automatic model_step();
        bit [7:0] em;
        int en[$];
        int nxt;
        em = eff_mask(ch_mask);
        for (int i = 0; i < 8; i++) if (em[i]) en.push_back(i);
        exp_sd = 0; exp_err = 0;
        if (!m_run) begin
            if (start && !stop) begin
                if (en.size() == 0) exp_err = 1;
                else begin
                    m_run = 1; m_ch = en[0]; m_left = int'(dwell); m_os = oneshot;
                end
            end
        end else if (stop) begin
            m_run = 0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (en.size() == 0) begin
            m_run = 0; exp_err = 1;
        end else begin
            nxt = -1;
            foreach (en[k]) if (en[k] > m_ch && nxt < 0) nxt = en[k];
            if (nxt >= 0) begin
                m_ch = nxt; m_left = int'(dwell);
            end else begin
                exp_sd = 1;
                if (m_os) m_run = 0;
                else begin m_ch = en[0]; m_left = int'(dwell); end
            end
        end
    endtask

    // one clock: model consumes the inputs at the edge, outputs compared after
    task automatic tick(input string name);
        logic [5:0] exp_v;
        @(posedge clk);
        model_step();
        #1;
        exp_v = {(m_run ? 3'(m_ch) : 3'd0), m_run, exp_sd, exp_err};
        check(name, {S, active, sweep_done, err}, exp_v);
    endtask

    typedef struct {
        logic       start;
        logic       stop;
        logic [7:0] mask;
        logic [7:0] dwell;
        logic [2:0] exp_s;
        logic       exp_act;
        logic       exp_sd;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int held;
        bit found;

        // full-mask, dwell 0, continuous sweep: identical in both builds
        vecs[0]  = '{0, 0, 8'hFF, 8'd0, 3'd0, 0, 0};
        vecs[1]  = '{0, 0, 8'hFF, 8'd0, 3'd0, 0, 0};
        vecs[2]  = '{1, 0, 8'hFF, 8'd0, 3'd0, 1, 0};
        for (int i = 3; i <= 9; i++) vecs[i] = '{0, 0, 8'hFF, 8'd0, 3'(i - 2), 1, 0};
        vecs[10] = '{0, 0, 8'hFF, 8'd0, 3'd0, 1, 1};
        vecs[11] = '{0, 0, 8'hFF, 8'd0, 3'd1, 1, 0};
        vecs[12] = '{0, 1, 8'hFF, 8'd0, 3'd0, 0, 0};

        rst_n = 0; start = 0; stop = 0; oneshot = 0; dwell = 0; ch_mask = 8'hFF;
        model_reset();
        #2;
        check("reset_outputs", {S, active, sweep_done, err}, 6'd0);
        #10 rst_n = 1;

        for (int i = 0; i < 13; i++) begin
            start = vecs[i].start; stop = vecs[i].stop;
            ch_mask = vecs[i].mask; dwell = vecs[i].dwell;
            tick($sformatf("vec%0d_model", i));
            check($sformatf("vec%0d_table", i), {S, active, sweep_done},
                  {vecs[i].exp_s, vecs[i].exp_act, vecs[i].exp_sd});
        end
        stop = 0;

        // oneshot over a sparse mask; sweep_done lands with active low
        ch_mask = 8'b1010_0100; dwell = 2; oneshot = 1; start = 1;
        tick("oneshot_start");
        start = 0; held = 0;
        for (int i = 0; i < 30; i++) begin
            tick("oneshot_run");
            if (sweep_done && !active) held++;
        end
        check("oneshot_done_idle", held, 1);
        oneshot = 0;

        // empty mask at start
        ch_mask = 8'h00; dwell = 1; start = 1;
        tick("empty_start");
`ifdef SCAN_SKIP_EN
        check("empty_err", {active, err}, 2'b01);
`else
        check("empty_ignored", {active, err}, 2'b10);
`endif
        start = 0;
        tick("empty_after");
        stop = 1;
        tick("empty_stop");
        stop = 0;

        // stop and start together at S=3, counter=1
        ch_mask = 8'hFF; dwell = 3; start = 1;
        tick("ss_start");
        start = 0;
        for (int i = 0; i < 13; i++) tick("ss_run");
        check("ss_at3", {S, active}, {3'd3, 1'b1});
        stop = 1; start = 1;
        tick("ss_both");
        check("ss_idle", {S, active, sweep_done}, 5'd0);
        stop = 0; start = 0;
        tick("ss_stay_idle");

        // clear the current channel mid-dwell
        ch_mask = 8'b0001_0110; dwell = 3; start = 1;
        tick("mask_start");
        start = 0; held = 0;
        for (int i = 0; i < 40; i++) begin
            tick("mask_run");
            if (S == 3'd2 && active) begin
                held++;
                if (held == 2) ch_mask = 8'b0001_0010;
            end else if (held > 0) break;
        end
        check("mask_dwell_kept", held, 4);
        for (int i = 0; i < 30; i++) tick("mask_after");
        stop = 1;
        tick("mask_stop");
        stop = 0;

        // asynchronous reset mid-dwell at S=5
        ch_mask = 8'b0010_0110; dwell = 4; start = 1;
        tick("rst_start");
        start = 0; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick("rst_run");
            if (S == 3'd5 && active) found = 1;
        end
        check("rst_reached5", found, 1);
        tick("rst_mid");
        #2 rst_n = 0;
        #1 check("rst_async_zero", {S, active, sweep_done, err}, 6'd0);
        model_reset();
        #2 rst_n = 1;
        tick("rst_idle1");
        tick("rst_idle2");
        start = 1;
        tick("rst_restart");
`ifdef SCAN_SKIP_EN
        check("rst_restart_low", {S, active}, {3'd1, 1'b1});
`else
        check("rst_restart_low", {S, active}, {3'd0, 1'b1});
`endif
        start = 0;

        // randomized run
        for (int i = 0; i < 400; i++) begin
            start   = ($urandom % 4) == 0;
            stop    = ($urandom % 16) == 0;
            oneshot = $urandom % 2;
            dwell   = 8'($urandom % 4);
            ch_mask = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
            tick("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
